// File: rtl/rx_lane_arbiter_if.sv
// Output stream of the receive-lane arbiter: one tagged word per handshake.
// The master drives data, lane tag and valid; the slave (capture FIFO) drives ready.
interface rx_lane_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 3
);
    logic [DATA_W-1:0] m_data;
    logic [LANE_W-1:0] m_lane;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_lane,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_lane,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/rx_lane_arbiter.sv
// Receive-lane arbiter: buffers each lane's words in a small circular FIFO and
// merges them onto one ready/valid output with round-robin fairness. Words
// arriving at a full, non-draining buffer are dropped, counted and flagged.
module rx_lane_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2,
    parameter int LANE_W    = 3
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    input  logic [NUM_LANES-1:0]        lane_valid,
    input  logic [NUM_LANES-1:0]        lane_en,
    rx_lane_arbiter_if.master           m_axis,
    input  logic                        clear_stats,
    output logic [15:0]                 drop_count,
    output logic [NUM_LANES-1:0]        overflow
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(NUM_LANES + 1);

    // Per-lane buffer status and handshake terms
    logic [NUM_LANES-1:0] buf_empty;
    logic [NUM_LANES-1:0] buf_full;
    logic [NUM_LANES-1:0] buf_push;
    logic [NUM_LANES-1:0] buf_pop;
    logic [NUM_LANES-1:0] lane_drop;
    logic [DATA_W-1:0]    head_data [NUM_LANES];

    // Scheduler and output register
    logic [LANE_W-1:0] rr_reg;
    logic [LANE_W-1:0] rr_next;
    logic [LANE_W-1:0] grant;
    logic              grant_valid;
    logic [DATA_W-1:0] head_sel;
    logic              out_free;
    logic [DATA_W-1:0] m_data_reg;
    logic [LANE_W-1:0] m_lane_reg;
    logic              m_valid_reg;

    // Statistics
    logic [CW-1:0]     drop_sum;
    logic [16:0]       drop_total;
    logic [15:0]       drop_count_next;

    assign out_free = !m_valid_reg || m_axis.m_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [BUF_DEPTH];
            logic [AW:0]       wr_ptr_reg;
            logic [AW:0]       rd_ptr_reg;
            logic              capture;

            // Extra pointer bit tells full (MSBs differ) from empty (equal)
            assign buf_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign buf_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign head_data[gi] = mem[rd_ptr_reg[AW-1:0]];

            // lane_en gates capture only; a full buffer draining this edge still accepts
            assign capture        = lane_valid[gi] && lane_en[gi];
            assign buf_pop[gi]    = out_free && grant_valid && (grant == LANE_W'(gi));
            assign buf_push[gi]   = capture && (!buf_full[gi] || buf_pop[gi]);
            assign lane_drop[gi]  = capture && buf_full[gi] && !buf_pop[gi];

            // Advance read/write pointers; reset empties the buffer
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (buf_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (buf_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // Buffer storage; contents are meaningless while the pointers say empty
            always_ff @(posedge aclk) begin
                if (buf_push[gi]) mem[wr_ptr_reg[AW-1:0]] <= lane_data[gi*DATA_W +: DATA_W];
            end
        end
    endgenerate

    // Round-robin search from rr upward, wrapping, for the first non-empty buffer
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!grant_valid && !buf_empty[idx]) begin
                grant       = LANE_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // Select the granted lane's head word and compute the next rr pointer
    always_comb begin
        head_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant == LANE_W'(i)) head_sel = head_data[i];
        end
        rr_next = (int'(grant) == NUM_LANES - 1) ? '0 : grant + LANE_W'(1);
    end

    // Output register: load when free, hold while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_lane_reg  <= '0;
            rr_reg      <= '0;
        end else if (out_free) begin
            m_valid_reg <= grant_valid;
            if (grant_valid) begin
                m_data_reg <= head_sel;
                m_lane_reg <= grant;
                rr_reg     <= rr_next;
            end
        end
    end

    assign m_axis.m_data  = m_data_reg;
    assign m_axis.m_lane  = m_lane_reg;
    assign m_axis.m_valid = m_valid_reg;

    // Count dropping lanes this edge and form the saturated total
    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            drop_sum = drop_sum + CW'(lane_drop[i]);
        end
        drop_total      = {1'b0, drop_count} + 17'(drop_sum);
        drop_count_next = drop_total[16] ? 16'hFFFF : drop_total[15:0];
    end

    // Drop statistics; a clear wins over drops on the same edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_count <= '0;
            overflow   <= '0;
        end else if (clear_stats) begin
            drop_count <= '0;
            overflow   <= '0;
        end else begin
            drop_count <= drop_count_next;
            overflow   <= overflow | lane_drop;
        end
    end
endmodule
